// File: rtl/nand_page_reader.sv
// nand_page_reader: NAND flash page-read controller.
// Issues READ (0x00), ADDR_CYC address bytes (byte 0 first) and the confirm
// command (0x30). It then waits out tWB, waits for R/B# and streams read_len
// words with programmable RE# timing. Bus writes use programmable WE# timing.
// Optional feature macro RB_TIMEOUT_EN adds an R/B# timeout that raises busy_err.
module nand_page_reader #(
  parameter int DQ_W        = 8,
  parameter int ADDR_CYC    = 5,
  parameter int LEN_W       = 12,
  parameter int WE_LOW_CYC  = 1,
  parameter int WE_HIGH_CYC = 1,
  parameter int RE_LOW_CYC  = 2,
  parameter int RE_HIGH_CYC = 1,
  parameter int WB_CYC      = 10,
  parameter int TO_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*ADDR_CYC-1:0]   addr,
  input  logic [LEN_W-1:0]        read_len,
  input  logic                    nand_rb,
  input  logic [DQ_W-1:0]         nand_dq_in,
  output logic                    nand_ce_n,
  output logic                    nand_cle,
  output logic                    nand_ale,
  output logic                    nand_we_n,
  output logic                    nand_re_n,
  output logic [DQ_W-1:0]         nand_dq_out,
  output logic                    nand_dq_oe,
  output logic [DQ_W-1:0]         data_out,
  output logic                    data_valid,
  output logic                    ready,
  output logic                    complete,
  output logic                    busy_err
);

  localparam int ADDR_W = 8 * ADDR_CYC;
  localparam int CNT_W  = 16;
  localparam int AB_W   = (ADDR_CYC > 1) ? $clog2(ADDR_CYC) : 1;

  localparam logic [7:0]       CMD_READ    = 8'h00;
  localparam logic [7:0]       CMD_CONFIRM = 8'h30;
  localparam logic [CNT_W-1:0] WE_LO_LAST  = CNT_W'(WE_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WE_HI_LAST  = CNT_W'(WE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] RE_LO_LAST  = CNT_W'(RE_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RE_HI_LAST  = CNT_W'(RE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] WB_LAST     = CNT_W'(WB_CYC - 1);
  localparam logic [AB_W-1:0]  AB_LAST     = AB_W'(ADDR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_WAIT_WB, S_WAIT_RB, S_READ, S_DONE
  } state_e;

  // Command/address bytes are zero-extended onto the DQ bus.
  function automatic logic [DQ_W-1:0] to_dq(input logic [7:0] b);
    return DQ_W'(b);
  endfunction

  state_e            state_q;
  logic [CNT_W-1:0]  cyc_q;       // clocks spent in the current strobe phase / tWB
  logic              hi_q;        // 0: strobe low phase, 1: strobe high phase
  logic [ADDR_W-1:0] addr_q;      // shifts down one byte per address write
  logic [AB_W-1:0]   abyte_q;     // index of the address byte being written
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_q;      // words captured so far
  logic              rb_meta_q;
  logic              rb_sync_q;

  logic              ce_n_q, cle_q, ale_q, we_n_q, re_n_q, dq_oe_q;
  logic [DQ_W-1:0]   dq_out_q, data_out_q;
  logic              data_valid_q, ready_q, complete_q;

  logic [CNT_W-1:0]  cyc_d;
  logic [LEN_W-1:0]  word_d;
  logic [ADDR_W-1:0] addr_sh_d;

  assign cyc_d     = cyc_q + CNT_W'(1);
  assign word_d    = word_q + LEN_W'(1);
  assign addr_sh_d = addr_q >> 8;

`ifdef RB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            busy_err_q;

  assign to_cnt_d = to_cnt_q + TO_W'(1);
  assign busy_err = busy_err_q;
`else
  // Without the timeout feature TO_W sizes nothing and the flag folds to 0.
  assign busy_err = (TO_W < 0) ? 1'b1 : 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous R/B# pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      rb_meta_q <= nand_rb;
      rb_sync_q <= rb_meta_q;
    end
  end

  // Sequencer: walks the page-read protocol and drives every pin from a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      hi_q         <= 1'b0;
      addr_q       <= '0;
      abyte_q      <= '0;
      len_q        <= '0;
      word_q       <= '0;
      ce_n_q       <= 1'b1;
      cle_q        <= 1'b0;
      ale_q        <= 1'b0;
      we_n_q       <= 1'b1;
      re_n_q       <= 1'b1;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      complete_q   <= 1'b0;
`ifdef RB_TIMEOUT_EN
      to_cnt_q     <= '0;
      busy_err_q   <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      complete_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q   <= addr;
            len_q    <= read_len;
            word_q   <= '0;
            abyte_q  <= '0;
            ready_q  <= 1'b0;
            ce_n_q   <= 1'b0;
            cle_q    <= 1'b1;
            ale_q    <= 1'b0;
            dq_out_q <= to_dq(CMD_READ);
            dq_oe_q  <= 1'b1;
            we_n_q   <= 1'b0;
            cyc_q    <= '0;
            hi_q     <= 1'b0;
            state_q  <= S_CMD1;
`ifdef RB_TIMEOUT_EN
            busy_err_q <= 1'b0;
`endif
          end
        end

        S_CMD1, S_ADDR, S_CMD2: begin
          if (!hi_q) begin
            if (cyc_q == WE_LO_LAST) begin
              we_n_q <= 1'b1;
              hi_q   <= 1'b1;
              cyc_q  <= '0;
            end else begin
              cyc_q <= cyc_d;
            end
          end else if (cyc_q != WE_HI_LAST) begin
            cyc_q <= cyc_d;
          end else begin
            // Write finished: the next write (if any) starts on this same edge.
            cyc_q <= '0;
            hi_q  <= 1'b0;
            if (state_q == S_CMD1) begin
              cle_q    <= 1'b0;
              ale_q    <= 1'b1;
              dq_out_q <= to_dq(addr_q[7:0]);
              we_n_q   <= 1'b0;
              state_q  <= S_ADDR;
            end else if (state_q == S_ADDR) begin
              if (abyte_q == AB_LAST) begin
                ale_q    <= 1'b0;
                cle_q    <= 1'b1;
                dq_out_q <= to_dq(CMD_CONFIRM);
                we_n_q   <= 1'b0;
                state_q  <= S_CMD2;
              end else begin
                abyte_q  <= abyte_q + AB_W'(1);
                addr_q   <= addr_sh_d;
                dq_out_q <= to_dq(addr_sh_d[7:0]);
                we_n_q   <= 1'b0;
              end
            end else begin
              cle_q    <= 1'b0;
              dq_oe_q  <= 1'b0;
              dq_out_q <= '0;
              state_q  <= S_WAIT_WB;
            end
          end
        end

        S_WAIT_WB: begin
          if (cyc_q == WB_LAST) begin
            cyc_q   <= '0;
            state_q <= S_WAIT_RB;
`ifdef RB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end else begin
            cyc_q <= cyc_d;
          end
        end

        S_WAIT_RB: begin
          if (rb_sync_q) begin
            if (len_q == '0) begin
              ce_n_q     <= 1'b1;
              complete_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              re_n_q  <= 1'b0;
              cyc_q   <= '0;
              hi_q    <= 1'b0;
              state_q <= S_READ;
            end
          end
`ifdef RB_TIMEOUT_EN
          else if (to_cnt_d == '1) begin
            busy_err_q <= 1'b1;
            ce_n_q     <= 1'b1;
            complete_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
`endif
        end

        S_READ: begin
          if (!hi_q) begin
            if (cyc_q == RE_LO_LAST) begin
              // Capture on the last low clock, the same edge that raises RE#.
              re_n_q       <= 1'b1;
              data_out_q   <= nand_dq_in;
              data_valid_q <= 1'b1;
              word_q       <= word_d;
              hi_q         <= 1'b1;
              cyc_q        <= '0;
            end else begin
              cyc_q <= cyc_d;
            end
          end else if (cyc_q != RE_HI_LAST) begin
            cyc_q <= cyc_d;
          end else begin
            cyc_q <= '0;
            hi_q  <= 1'b0;
            if (word_q == len_q) begin
              ce_n_q     <= 1'b1;
              complete_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              re_n_q <= 1'b0;
            end
          end
        end

        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          ce_n_q  <= 1'b1;
          cle_q   <= 1'b0;
          ale_q   <= 1'b0;
          we_n_q  <= 1'b1;
          re_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign nand_ce_n   = ce_n_q;
  assign nand_cle    = cle_q;
  assign nand_ale    = ale_q;
  assign nand_we_n   = we_n_q;
  assign nand_re_n   = re_n_q;
  assign nand_dq_out = dq_out_q;
  assign nand_dq_oe  = dq_oe_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign ready       = ready_q;
  assign complete    = complete_q;

endmodule

// File: tb/tb_nand_page_reader.sv
// Scoreboard bench for nand_page_reader: a default-parameter instance and a
// 16-bit instance with stretched WE#/RE# timing. Device models answer R/B# and
// DQ reads; monitors pop expected bus writes, data words and completions.
// With RB_TIMEOUT_EN defined an R/B# timeout scenario is also run (TO_W=6).
module tb_nand_page_reader;

  localparam int A_WE_LOW = 1;
  localparam int A_RE_LOW = 2;
  localparam int B_WE_LOW = 3;
  localparam int B_RE_LOW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic        a_start = 1'b0;
  logic [39:0] a_addr  = '0;
  logic [11:0] a_len   = '0;
  logic        a_rb;
  logic [7:0]  a_dq_in;
  logic        a_ce_n, a_cle, a_ale, a_we_n, a_re_n, a_dq_oe, a_dv, a_ready, a_cmpl, a_berr;
  logic [7:0]  a_dq_out, a_dout;

  nand_page_reader #(.TO_W(6)) dut (
    .clk(clk), .reset(rst_n), .start(a_start), .addr(a_addr), .read_len(a_len),
    .nand_rb(a_rb), .nand_dq_in(a_dq_in), .nand_ce_n(a_ce_n), .nand_cle(a_cle),
    .nand_ale(a_ale), .nand_we_n(a_we_n), .nand_re_n(a_re_n), .nand_dq_out(a_dq_out),
    .nand_dq_oe(a_dq_oe), .data_out(a_dout), .data_valid(a_dv), .ready(a_ready),
    .complete(a_cmpl), .busy_err(a_berr));

  // 16-bit instance with WE# low 3 clocks and RE# low 4 clocks
  logic        b_start = 1'b0;
  logic [39:0] b_addr  = '0;
  logic [11:0] b_len   = '0;
  logic        b_rb    = 1'b1;
  logic [15:0] b_dq_in;
  logic        b_ce_n, b_cle, b_ale, b_we_n, b_re_n, b_dq_oe, b_dv, b_ready, b_cmpl, b_berr;
  logic [15:0] b_dq_out, b_dout;

  nand_page_reader #(.DQ_W(16), .WE_LOW_CYC(B_WE_LOW), .RE_LOW_CYC(B_RE_LOW)) dut16 (
    .clk(clk), .reset(rst_n), .start(b_start), .addr(b_addr), .read_len(b_len),
    .nand_rb(b_rb), .nand_dq_in(b_dq_in), .nand_ce_n(b_ce_n), .nand_cle(b_cle),
    .nand_ale(b_ale), .nand_we_n(b_we_n), .nand_re_n(b_re_n), .nand_dq_out(b_dq_out),
    .nand_dq_oe(b_dq_oe), .data_out(b_dout), .data_valid(b_dv), .ready(b_ready),
    .complete(b_cmpl), .busy_err(b_berr));

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  exp_wr_q[$];
  logic [7:0]  exp_dat_q[$];
  logic        exp_cmpl_q[$];
  logic [7:0]  dev_q[$];
  logic [17:0] exp_wr16_q[$];
  logic [15:0] exp_dat16_q[$];

  int a_dv_cnt    = 0;
  int a_re_pulses = 0;
  int a_cmpl_cnt  = 0;
  int b_cmpl_cnt  = 0;
  int rb_low_len  = 0;
  bit rb_hold     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor for the default instance: scoreboard pops and pin timing checks.
  initial begin : mon_a
    int we_run, re_run;
    logic prev_we, prev_re, prev_dv, prev_cmpl;
    logic [9:0] ew;
    logic [7:0] ed;
    logic       eb;
    we_run = 0; re_run = 0; prev_we = 1'b1; prev_re = 1'b1; prev_dv = 1'b0; prev_cmpl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        we_run = 0; re_run = 0; prev_we = 1'b1; prev_re = 1'b1; prev_dv = 1'b0; prev_cmpl = 1'b0;
      end else begin
        if (!a_we_n) we_run++;
        else if (!prev_we) begin
          check("a_we_low_clocks", 64'(we_run), 64'(A_WE_LOW));
          check("a_write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
          if (exp_wr_q.size() != 0) begin
            ew = exp_wr_q.pop_front();
            check("a_bus_write", 64'({a_cle, a_ale, a_dq_out}), 64'(ew));
          end
          check("a_dq_oe_write", 64'(a_dq_oe), 64'd1);
          we_run = 0;
        end
        if (!a_re_n) re_run++;
        else if (!prev_re) begin
          a_re_pulses++;
          check("a_re_low_clocks", 64'(re_run), 64'(A_RE_LOW));
          re_run = 0;
        end
        if (a_dv) begin
          a_dv_cnt++;
          check("a_dv_at_re_rise", 64'(!prev_re && a_re_n), 64'd1);
          check("a_data_expected", 64'(exp_dat_q.size() != 0), 64'd1);
          if (exp_dat_q.size() != 0) begin
            ed = exp_dat_q.pop_front();
            check("a_data_out", 64'(a_dout), 64'(ed));
          end
        end
        if (prev_dv) check("a_dv_one_cycle", 64'(a_dv), 64'd0);
        if (a_cmpl) begin
          a_cmpl_cnt++;
          check("a_complete_expected", 64'(exp_cmpl_q.size() != 0), 64'd1);
          if (exp_cmpl_q.size() != 0) begin
            eb = exp_cmpl_q.pop_front();
            check("a_busy_err_at_done", 64'(a_berr), 64'(eb));
          end
          check("a_ce_n_at_done", 64'({a_ce_n, a_re_n, a_ready}), 64'(3'b110));
        end
        if (prev_cmpl) begin
          check("a_complete_one_cycle", 64'(a_cmpl), 64'd0);
          check("a_ready_after_done", 64'(a_ready), 64'd1);
        end
        prev_we = a_we_n; prev_re = a_re_n; prev_dv = a_dv; prev_cmpl = a_cmpl;
      end
    end
  end

  // Device model for the default instance: R/B# busy window and read data.
  initial begin : dev_a
    logic pw, pr;
    int   rbc;
    a_rb = 1'b1; a_dq_in = 8'h00; pw = 1'b1; pr = 1'b1; rbc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pw = 1'b1; pr = 1'b1; rbc = 0;
      end else begin
        if (rbc > 0) rbc--;
        if (!pw && a_we_n && a_cle && (a_dq_out == 8'h30)) rbc = rb_low_len;
        if (pr && !a_re_n) begin
          if (dev_q.size() != 0) a_dq_in = dev_q.pop_front();
          else a_dq_in = 8'hEE;
        end
        pw = a_we_n; pr = a_re_n;
      end
      a_rb = !rb_hold && (rbc == 0);
    end
  end

  // Monitor for the 16-bit instance.
  initial begin : mon_b
    int we_run, re_run;
    logic pw, pr;
    logic [17:0] ew;
    logic [15:0] ed;
    we_run = 0; re_run = 0; pw = 1'b1; pr = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        we_run = 0; re_run = 0; pw = 1'b1; pr = 1'b1;
      end else begin
        if (!b_we_n) we_run++;
        else if (!pw) begin
          check("b_we_low_clocks", 64'(we_run), 64'(B_WE_LOW));
          check("b_write_expected", 64'(exp_wr16_q.size() != 0), 64'd1);
          if (exp_wr16_q.size() != 0) begin
            ew = exp_wr16_q.pop_front();
            check("b_bus_write", 64'({b_cle, b_ale, b_dq_out}), 64'(ew));
          end
          we_run = 0;
        end
        if (!b_re_n) re_run++;
        else if (!pr) begin
          check("b_re_low_clocks", 64'(re_run), 64'(B_RE_LOW));
          re_run = 0;
        end
        if (b_dv) begin
          check("b_data_expected", 64'(exp_dat16_q.size() != 0), 64'd1);
          if (exp_dat16_q.size() != 0) begin
            ed = exp_dat16_q.pop_front();
            check("b_data_out", 64'(b_dout), 64'(ed));
          end
        end
        if (b_cmpl) b_cmpl_cnt++;
        pw = b_we_n; pr = b_re_n;
      end
    end
  end

  // Device model for the 16-bit instance: DQ encodes word index and low-clock number.
  initial begin : dev_b
    int   k, w;
    logic pr;
    b_dq_in = 16'h0000; k = 0; w = 0; pr = 1'b1;
    forever begin
      @(negedge clk);
      if (!b_re_n) begin
        k++;
        b_dq_in = {8'hB0 + 8'(w), 8'(k)};
      end else if (!pr) begin
        w++;
        k = 0;
      end
      pr = b_re_n;
    end
  end

  task automatic check_idle_a(input string name);
    check({name, "_ctrl"},
          64'({a_ce_n, a_cle, a_ale, a_we_n, a_re_n, a_dq_oe, a_dv, a_ready, a_cmpl, a_berr}),
          64'(10'b1001100100));
    check({name, "_data"}, 64'({a_dq_out, a_dout}), 64'd0);
  endtask

  task automatic wait_ready_a(input string name, input int budget);
    int n;
    n = 0;
    while (!a_ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(a_ready), 64'd1);
  endtask

  task automatic issue_a(input logic [39:0] ad, input logic [11:0] len, input logic [7:0] base,
                         input int rbl, input int n_exp, input bit want_cmpl, input logic exp_berr);
    rb_low_len = rbl;
    exp_wr_q.push_back({2'b10, 8'h00});
    for (int i = 0; i < 5; i++) exp_wr_q.push_back({2'b01, ad[8*i +: 8]});
    exp_wr_q.push_back({2'b10, 8'h30});
    for (int i = 0; i < int'(len); i++) begin
      dev_q.push_back(base + 8'(2*i));
      if (i < n_exp) exp_dat_q.push_back(base + 8'(2*i));
    end
    if (want_cmpl) exp_cmpl_q.push_back(exp_berr);
    @(posedge clk); #1;
    a_start = 1'b1; a_addr = ad; a_len = len;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_accept_pins", 64'({a_ready, a_ce_n, a_cle, a_ale, a_we_n, a_dq_oe}), 64'(6'b001001));
  endtask

  initial begin : stim
    int c0, r0, d0, n;
    #1 rst_n = 1'b0;
    #2;
    check_idle_a("a_reset_state");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_a("a_after_reset_release");

    // Basic page read: 4 words after a 20-clock busy window
    c0 = a_cmpl_cnt;
    issue_a(40'h00_0000_000F, 12'd4, 8'h55, 20, 4, 1'b1, 1'b0);
    wait_ready_a("a_t1_done", 600);
    check("a_t1_complete_count", 64'(a_cmpl_cnt - c0), 64'd1);

    // read_len = 0: no RE# pulses, no data
    c0 = a_cmpl_cnt; r0 = a_re_pulses; d0 = a_dv_cnt;
    issue_a(40'h11_2233_4455, 12'd0, 8'h00, 5, 0, 1'b1, 1'b0);
    wait_ready_a("a_t2_done", 600);
    check("a_t2_complete_count", 64'(a_cmpl_cnt - c0), 64'd1);
    check("a_t2_no_re_pulse", 64'(a_re_pulses - r0), 64'd0);
    check("a_t2_no_data_valid", 64'(a_dv_cnt - d0), 64'd0);

    // Reset during READ after the second word
    c0 = a_cmpl_cnt; d0 = a_dv_cnt;
    issue_a(40'h99_8877_6655, 12'd4, 8'h10, 3, 2, 1'b0, 1'b0);
    n = 0;
    while ((a_dv_cnt - d0) < 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("a_t3_two_words_seen", 64'(a_dv_cnt - d0), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle_a("a_t3_async_reset");
    dev_q.delete();
    exp_dat_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("a_t3_no_complete", 64'(a_cmpl_cnt - c0), 64'd0);
    issue_a(40'h00_0000_0123, 12'd2, 8'h20, 4, 2, 1'b1, 1'b0);
    wait_ready_a("a_t3_restart_done", 600);
    check("a_t3_restart_complete", 64'(a_cmpl_cnt - c0), 64'd1);

    // start while busy is ignored
    c0 = a_cmpl_cnt;
    issue_a(40'h0A_0B0C_0D0E, 12'd1, 8'h80, 2, 1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 a_start = 1'b1; a_addr = 40'hFF_FFFF_FFFF; a_len = 12'd7;
    @(posedge clk); #1 a_start = 1'b0;
    wait_ready_a("a_t4_done", 600);
    repeat (6) @(posedge clk); #1;
    check("a_t4_one_complete", 64'(a_cmpl_cnt - c0), 64'd1);
    check("a_t4_stays_idle", 64'({a_ready, a_ce_n}), 64'(2'b11));

    // 16-bit instance with stretched strobes
    exp_wr16_q.push_back(18'h20000);
    exp_wr16_q.push_back(18'h10005);
    exp_wr16_q.push_back(18'h10004);
    exp_wr16_q.push_back(18'h10003);
    exp_wr16_q.push_back(18'h10002);
    exp_wr16_q.push_back(18'h10001);
    exp_wr16_q.push_back(18'h20030);
    exp_dat16_q.push_back(16'hB004);
    exp_dat16_q.push_back(16'hB104);
    @(posedge clk); #1;
    b_start = 1'b1; b_addr = 40'h01_0203_0405; b_len = 12'd2;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0;
    while (!b_ready && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_done", 64'(b_ready), 64'd1);
    check("b_complete_count", 64'(b_cmpl_cnt), 64'd1);
    check("b_busy_err", 64'(b_berr), 64'd0);

`ifdef RB_TIMEOUT_EN
    // R/B# stuck low: timeout sets busy_err, skips READ, still completes
    c0 = a_cmpl_cnt; r0 = a_re_pulses;
    rb_hold = 1'b1;
    issue_a(40'h00_0000_0042, 12'd3, 8'h40, 0, 0, 1'b1, 1'b1);
    wait_ready_a("a_t5_done", 600);
    dev_q.delete();
    check("a_t5_busy_err", 64'(a_berr), 64'd1);
    check("a_t5_no_re_pulse", 64'(a_re_pulses - r0), 64'd0);
    check("a_t5_complete", 64'(a_cmpl_cnt - c0), 64'd1);
    rb_hold = 1'b0;
    issue_a(40'h00_0000_0043, 12'd1, 8'h60, 2, 1, 1'b1, 1'b0);
    check("a_t5_busy_err_cleared", 64'(a_berr), 64'd0);
    wait_ready_a("a_t5_recover_done", 600);
`else
    check("a_busy_err_tied", 64'(a_berr), 64'd0);
`endif

    repeat (3) @(posedge clk); #1;
    check("a_writes_drained", 64'(exp_wr_q.size()), 64'd0);
    check("a_data_drained", 64'(exp_dat_q.size()), 64'd0);
    check("a_cmpl_drained", 64'(exp_cmpl_q.size()), 64'd0);
    check("b_writes_drained", 64'(exp_wr16_q.size()), 64'd0);
    check("b_data_drained", 64'(exp_dat16_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_page_reader.md
Name: nand_page_reader

Overview:
- Parametrised NAND flash page-read controller; successor to the fixed 8-bit read sequencer.
- Issues READ command 0x00, ADDR_CYC address bytes and confirm 0x30, then waits on R/B#.
- Streams a run-time-selected number of data words out of the device with programmable WE#/RE# pulse timing.
- Sits between the page-buffer/host logic and the NAND pins.

Parameters:
- DQ_W, 8: NAND data bus width (8 or 16).
- ADDR_CYC, 5: number of address cycles; ADDR_W = 8*ADDR_CYC.
- LEN_W, 12: width of read_len (maximum 4095 words per transfer).
- WE_LOW_CYC, 1: clocks WE# held low per bus write (≥1).
- WE_HIGH_CYC, 1: clocks WE# held high per bus write (≥1).
- RE_LOW_CYC, 2: clocks RE# held low per data read (≥1).
- RE_HIGH_CYC, 1: clocks RE# held high per data read (≥1).
- WB_CYC, 10: tWB guard, in clocks, after the confirm command before R/B# is examined.
- TO_W, 16: width of the R/B# timeout counter (used only with RB_TIMEOUT_EN).

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request; sampled only in IDLE.
- addr, in, ADDR_W: page/column address; byte 0 (bits 7:0) is sent first.
- read_len, in, LEN_W: number of data words to read; latched with start.
- nand_rb, in, 1: R/B# (1 = ready); synchronised internally with a 2-flop synchroniser.
- nand_dq_in, in, DQ_W: data from the device.
- nand_ce_n, out, 1: chip enable.
- nand_cle, out, 1: command latch enable.
- nand_ale, out, 1: address latch enable.
- nand_we_n, out, 1: write enable.
- nand_re_n, out, 1: read enable.
- nand_dq_out, out, DQ_W: command/address byte, zero-extended to DQ_W.
- nand_dq_oe, out, 1: drive enable for nand_dq_out.
- data_out, out, DQ_W: captured read word.
- data_valid, out, 1: one-cycle strobe qualifying data_out.
- ready, out, 1: high only in IDLE.
- complete, out, 1: one-cycle pulse at end of transfer.
- busy_err, out, 1: R/B# timeout flag (tied 0 without RB_TIMEOUT_EN).

Behaviour:
- Reset values (asynchronous on reset=0):
  - ce_n=1, cle=0, ale=0, we_n=1, re_n=1.
  - dq_out=0, dq_oe=0, data_out=0, data_valid=0, complete=0, busy_err=0.
  - ready=1, state=IDLE, all counters 0.
- Reset mid-operation: pins return to the values above immediately; the transfer is abandoned; no complete pulse is generated.
- States: IDLE → CMD1 → ADDR → CMD2 → WAIT_WB → WAIT_RB → READ → DONE → IDLE.
- IDLE: ready=1. start=1 at edge k latches addr and read_len; at k+1 ready=0, ce_n=0, state=CMD1. start outside IDLE is ignored.
- Bus write (CMD1, ADDR, CMD2):
  - dq_oe=1; cle (command) or ale (address) and dq_out are held stable for the whole write.
  - we_n=0 for WE_LOW_CYC clocks, then 1 for WE_HIGH_CYC clocks; the write ends after the high phase.
  - CMD1 drives 0x00. ADDR runs ADDR_CYC writes, address byte i on write i. CMD2 drives 0x30.
  - Between states cle/ale drop in the same cycle the next write begins; they are never both high.
- WAIT_WB: dq_oe=0, cle=ale=0; counts WB_CYC clocks, ignoring R/B#.
- WAIT_RB: waits for synchronised R/B#=1. If R/B# never went low, exit is immediate after WAIT_WB.
- READ:
  - Each word: re_n=0 for RE_LOW_CYC clocks, then re_n=1 for RE_HIGH_CYC clocks.
  - nand_dq_in is captured on the last low clock (at the edge that raises re_n). data_out updates and data_valid=1 for exactly that one following cycle.
  - Exactly read_len words are read; the word counter is LEN_W bits with no wrap (compare-equal termination).
  - read_len=0 skips READ: WAIT_RB goes directly to DONE, with no RE# pulses and no data_valid.
- DONE: ce_n=1, complete=1 for one cycle, then IDLE (ready=1 on the following cycle). A start on the first IDLE cycle is accepted.
- Outside READ, re_n stays 1. Outside bus writes, we_n stays 1. ce_n=0 from CMD1 through the end of READ.

Optional Feature:
- Macro: RB_TIMEOUT_EN.
- Defined:
  - WAIT_RB counts clocks in a TO_W-bit counter.
  - If the counter reaches all-ones with R/B# still 0: busy_err is set (sticky until the next accepted start or reset), READ is skipped, DONE is entered, and complete pulses.
- Undefined:
  - WAIT_RB waits indefinitely; busy_err is constant 0 and the counter is not synthesised.

Test Plan:
- Default parameters, addr=0x00_0000_000F, read_len=4, R/B# low for 20 clocks after the 0x30 write; device returns 0x55,0x57,0x59,0x5B.
  - Pin sequence on dq_out: 0x00 (cle), 0x0F,0x00,0x00,0x00,0x00 (ale), 0x30 (cle).
  - Four data_valid strobes carrying 0x55,0x57,0x59,0x5B, then one complete pulse.
- read_len=0 → no re_n low and no data_valid; complete pulses 1 cycle after R/B# is seen high.
- Assert reset while in READ after the 2nd word → all pins go to idle values asynchronously; no complete; a subsequent start with read_len=2 completes normally.
- Pulse start while busy → ignored: no address re-latch, exactly one complete per accepted start.
- WE_LOW_CYC=3, RE_LOW_CYC=4, DQ_W=16 → we_n low exactly 3 clocks per write; re_n low 4 clocks per word; 16-bit word captured on the 4th low clock.
- RB_TIMEOUT_EN, TO_W=6, R/B# held 0 → busy_err=1 and complete after 63 WAIT_RB clocks; no RE# pulses; busy_err clears on the next accepted start.
